// File: rtl/tc_pkg.sv
// Shared constants, scheduler state encoding and duty clamping for the
// temperature-control sample scheduler.
package tc_pkg;

    localparam int PWM_PERIOD = 1000;
    localparam int DUTY_W     = 11;
    localparam int TEMP_W     = 12;
    localparam int PER_W      = 10;
    localparam int HIGH_LEN_W = 16;

    localparam logic signed [HIGH_LEN_W-1:0] DUTY_MAX = 16'sd1000;

    typedef enum logic [2:0] {
        WAIT_WRAP = 3'd0,
        START     = 3'd1,
        WAIT_CONV = 3'd2,
        TRIG      = 3'd3,
        SETTLE    = 3'd4,
        CAPTURE   = 3'd5
    } sched_state_t;

    // Signed PID request limited to the 0..PWM_PERIOD duty range.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [HIGH_LEN_W-1:0] req);
        logic [DUTY_W-1:0] res;
        if (req < 16'sd0) begin
            res = '0;
        end else if (req > DUTY_MAX) begin
            res = DUTY_W'(PWM_PERIOD);
        end else begin
            res = req[DUTY_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM tick divider and 0..PWM_PERIOD-1 period counter; clr holds both at zero.
module pwm_timebase
    import tc_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [PER_W-1:0] per_cnt,
    output logic             tick,
    output logic             wrap
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    assign tick = !clr && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign wrap = tick && (per_cnt == PER_W'(PWM_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            per_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
            per_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                per_cnt <= wrap ? '0 : per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_sample_sched.sv
// One sensor conversion and one PID update per PWM period; the captured duty
// drives the heater over the following period.
module pwm_sample_sched
    import tc_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int CONV_TIMEOUT = 900,
    parameter int TRIG_LEN     = 4,
    parameter int SETTLE_LEN   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic                         conv_start,
    input  logic                         conv_done,
    input  logic [TEMP_W-1:0]            ds_data,
    output logic [TEMP_W-1:0]            temp_latched,
    output logic                         pid_trig,
    input  logic signed [HIGH_LEN_W-1:0] high_len,
    input  logic                         heater_open,
    input  logic                         fan_open,
    output logic                         heater_pwm,
    output logic                         fan_drv,
    output logic [DUTY_W-1:0]            duty,
    output logic                         sensor_fault,
    output logic                         overrun
);

    localparam int TO_W    = $clog2(CONV_TIMEOUT + 1);
    localparam int SEQ_MAX = (TRIG_LEN > SETTLE_LEN) ? TRIG_LEN : SETTLE_LEN;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    sched_state_t      state;
    logic [PER_W-1:0]  per_cnt;
    logic              tick;
    logic              wrap;
    logic              enable_d;
    logic [TO_W-1:0]   to_cnt;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [DUTY_W-1:0] duty_next;
    logic              conv_timeout;

    pwm_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .clr     (!enable),
        .per_cnt (per_cnt),
        .tick    (tick),
        .wrap    (wrap)
    );

    // The tick that brings the count to CONV_TIMEOUT is the expiry cycle.
    assign conv_timeout = tick && (to_cnt == TO_W'(CONV_TIMEOUT - 1));

    assign conv_start = enable && (state == START);
    assign pid_trig   = enable && (state == TRIG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_WRAP;
            enable_d     <= 1'b0;
            to_cnt       <= '0;
            seq_cnt      <= '0;
            duty_next    <= '0;
            duty         <= '0;
            temp_latched <= '0;
            sensor_fault <= 1'b0;
            overrun      <= 1'b0;
            heater_pwm   <= 1'b0;
            fan_drv      <= 1'b0;
        end else if (!enable) begin
            // Sensor status and last temperature survive a disable.
            state      <= WAIT_WRAP;
            enable_d   <= 1'b0;
            to_cnt     <= '0;
            seq_cnt    <= '0;
            duty_next  <= '0;
            duty       <= '0;
            overrun    <= 1'b0;
            heater_pwm <= 1'b0;
            fan_drv    <= 1'b0;
        end else begin
            enable_d   <= 1'b1;
            heater_pwm <= heater_open && !sensor_fault && (DUTY_W'(per_cnt) < duty);
            fan_drv    <= fan_open || sensor_fault;

            if (wrap) begin
                duty <= duty_next;
                if (state != WAIT_WRAP) begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                WAIT_WRAP: begin
                    if (wrap || !enable_d) begin
                        state <= START;
                    end
                end
                START: begin
                    to_cnt <= '0;
                    state  <= WAIT_CONV;
                end
                WAIT_CONV: begin
                    if (conv_done) begin
                        temp_latched <= ds_data;
                        sensor_fault <= 1'b0;
                        seq_cnt      <= '0;
                        state        <= TRIG;
                    end else if (conv_timeout) begin
                        sensor_fault <= 1'b1;
                        duty_next    <= '0;
                        state        <= WAIT_WRAP;
                    end else if (tick) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                TRIG: begin
                    if (seq_cnt == SEQ_W'(TRIG_LEN - 1)) begin
                        seq_cnt <= '0;
                        state   <= SETTLE;
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (seq_cnt == SEQ_W'(SETTLE_LEN - 1)) begin
                        seq_cnt <= '0;
                        state   <= CAPTURE;
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    duty_next <= clamp_duty(high_len);
                    state     <= WAIT_WRAP;
                end
                default: begin
                    state <= WAIT_WRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Directed bench for pwm_sample_sched with a 2-cycle tick (2000-cycle PWM period).
module tb_pwm_sample_sched;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               conv_done = 1'b0;
    logic [11:0]        ds_data = '0;
    logic signed [15:0] high_len = '0;
    logic               heater_open = 1'b0;
    logic               fan_open = 1'b0;

    logic        conv_start;
    logic [11:0] temp_latched;
    logic        pid_trig;
    logic        heater_pwm;
    logic        fan_drv;
    logic [10:0] duty;
    logic        sensor_fault;
    logic        overrun;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-window measurements filled by run_period.
    int len, heater_cnt, trig_cnt, trig_first, fault_first, cs_cnt;

    pwm_sample_sched #(
        .TICK_DIV     (2),
        .CONV_TIMEOUT (900),
        .TRIG_LEN     (4),
        .SETTLE_LEN   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .conv_start   (conv_start),
        .conv_done    (conv_done),
        .ds_data      (ds_data),
        .temp_latched (temp_latched),
        .pid_trig     (pid_trig),
        .high_len     (high_len),
        .heater_open  (heater_open),
        .fan_open     (fan_open),
        .heater_pwm   (heater_pwm),
        .fan_drv      (fan_drv),
        .duty         (duty),
        .sensor_fault (sensor_fault),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Window runs from a conv_start cycle up to the next one; conv_done is
    // pulsed at window cycle 'delay' (never when negative).
    task automatic run_period(input int delay);
        int wait_n;
        wait_n = 0;
        while (conv_start !== 1'b1 && wait_n < 4200) begin
            @(negedge clk);
            wait_n++;
        end
        check("period_start_seen", conv_start, 1);
        len = 0; heater_cnt = 0; trig_cnt = 0; trig_first = -1; fault_first = -1; cs_cnt = 0;
        do begin
            if (heater_pwm === 1'b1) heater_cnt++;
            if (conv_start === 1'b1) cs_cnt++;
            if (pid_trig === 1'b1) begin
                trig_cnt++;
                if (trig_first < 0) trig_first = len;
            end
            if (sensor_fault === 1'b1 && fault_first < 0) fault_first = len;
            conv_done = (len == delay);
            @(negedge clk);
            len++;
        end while (conv_start !== 1'b1 && len < 2100);
        conv_done = 1'b0;
        $display("period: len=%0d heater=%0d trig=%0d@%0d fault@%0d duty=%0d temp=%h",
                 len, heater_cnt, trig_cnt, trig_first, fault_first, duty, temp_latched);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_conv_start", conv_start, 0);
        check("rst_pid_trig", pid_trig, 0);
        check("rst_heater", heater_pwm, 0);
        check("rst_fan", fan_drv, 0);
        check("rst_duty", duty, 0);
        check("rst_fault_overrun", {sensor_fault, overrun}, 0);
        check("rst_temp", temp_latched, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Basic sequence
        heater_open = 1'b1;
        fan_open    = 1'b0;
        ds_data     = 12'h190;
        high_len    = 16'sd300;
        enable      = 1'b1;
        @(negedge clk);
        check("enable_conv_start", conv_start, 1);
        run_period(100);
        check("basic_temp", temp_latched, 12'h190);
        check("basic_trig_len", trig_cnt, 4);
        check("basic_trig_first", trig_first, 101);
        check("basic_first_len", len, 1999);
        check("basic_conv_start_len", cs_cnt, 1);
        check("basic_first_heater", heater_cnt, 0);
        check("basic_duty", duty, 300);
        run_period(100);
        check("basic_heater_600", heater_cnt, 600);
        check("basic_period_len", len, 2000);
        check("basic_no_overrun", overrun, 0);

        // 2. Clamping
        high_len = -16'sd50;
        run_period(100);
        check("clamp_neg_duty", duty, 0);
        run_period(100);
        check("clamp_neg_heater", heater_cnt, 0);
        high_len = 16'sd1500;
        run_period(100);
        check("clamp_pos_duty", duty, 1000);
        run_period(100);
        run_period(100);
        check("clamp_pos_heater", heater_cnt, 2000);

        // 3. Timeout, then recovery
        run_period(-1);
        check("timeout_fault_cycle", fault_first, 1800);
        check("timeout_no_trig", trig_cnt, 0);
        check("timeout_fault", sensor_fault, 1);
        check("timeout_fan", fan_drv, 1);
        check("timeout_heater", heater_pwm, 0);
        check("timeout_duty", duty, 0);
        ds_data = 12'h2A5;
        run_period(100);
        check("recover_fault", sensor_fault, 0);
        check("recover_temp", temp_latched, 12'h2A5);
        check("recover_fan", fan_drv, 0);
        check("recover_heater", heater_cnt, 0);

        // 4. conv_done on the expiry cycle
        high_len = 16'sd500;
        ds_data  = 12'h0AB;
        run_period(1799);
        check("simul_fault_never", fault_first, -1);
        check("simul_trig_first", trig_first, 1800);
        check("simul_trig_len", trig_cnt, 4);
        check("simul_temp", temp_latched, 12'h0AB);
        check("simul_duty", duty, 500);

        // 5. Drop enable during TRIG
        for (int i = 0; i < 102; i++) begin
            conv_done = (i == 100);
            @(negedge clk);
        end
        conv_done = 1'b0;
        check("dis_trig_before", pid_trig, 1);
        check("dis_heater_before", heater_pwm, 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_pid_trig", pid_trig, 0);
        check("dis_duty", duty, 0);
        check("dis_heater", heater_pwm, 0);
        check("dis_temp_held", temp_latched, 12'h0AB);
        repeat (5) @(negedge clk);
        check("dis_conv_start", conv_start, 0);
        enable = 1'b1;
        @(negedge clk);
        check("reen_conv_start", conv_start, 1);
        @(negedge clk);
        check("reen_conv_start_pulse", conv_start, 0);
        $display("reenable: conv_start pulse seen");

        // 6. Asynchronous reset mid-period with duty 500
        ds_data = 12'h321;
        run_period(100);
        check("pre_rst_duty", duty, 500);
        fan_open = 1'b1;
        repeat (300) @(negedge clk);
        check("pre_rst_heater", heater_pwm, 1);
        check("pre_rst_fan", fan_drv, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_duty", duty, 0);
        check("arst_heater", heater_pwm, 0);
        check("arst_fan", fan_drv, 0);
        check("arst_temp", temp_latched, 0);
        check("arst_strobes", {conv_start, pid_trig, sensor_fault, overrun}, 0);
        $display("async reset: outputs sampled 1 time unit after rst rise");
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_sample_sched.md
# pwm_sample_sched

Sequences one temperature control period: starts a sensor conversion, waits for it to finish, strobes the PID unit, then captures its `high_len` result and applies it as heater PWM duty over the next 1000-tick period. It sits between the DS18B20 reader, the PID/work unit and the heater/fan drivers. It replaces free-running sampling with one sample and one PID update per PWM period. On a sensor timeout it forces the plant into a safe state.

## Interface
Parameters:
- `TICK_DIV`, 50000: clk cycles per PWM tick (1 ms at 50 MHz).
- `CONV_TIMEOUT`, 900: ticks allowed from `conv_start` to `conv_done`. Must be less than 990.
- `TRIG_LEN`, 4: clk cycles that `pid_trig` is held high.
- `SETTLE_LEN`, 4: clk cycles waited after `pid_trig` falls before `high_len` is sampled.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: control enabled. Low means the same as `data_changing` being high.
- `conv_start` out 1: one-cycle pulse requesting a sensor conversion.
- `conv_done` in 1: one-cycle pulse; `ds_data` is valid in that cycle.
- `ds_data` in 12: temperature from the reader.
- `temp_latched` out 12: `ds_data` captured on `conv_done`.
- `pid_trig` out 1: strobe to the PID unit's `data_get_complete` input.
- `high_len` in 16 signed: duty request from the PID unit.
- `heater_open` in 1: heater enable from the PID unit.
- `fan_open` in 1: fan enable from the PID unit.
- `heater_pwm` out 1: PWM drive to the heater.
- `fan_drv` out 1: fan drive.
- `duty` out 11: active duty, 0..1000.
- `sensor_fault` out 1: latest conversion timed out.
- `overrun` out 1: sticky; a period wrap occurred while the FSM was busy.

## Operation
Counters:
- `div_cnt` counts 0..TICK_DIV-1 and produces `tick`.
- `per_cnt` counts 0..999 on `tick`. The `wrap` condition is `tick` && `per_cnt`==999.

FSM states: WAIT_WRAP, START, WAIT_CONV, TRIG, SETTLE, CAPTURE.
- **WAIT_WRAP → START** on `wrap`, and also in the first cycle after `enable` rises.
- **START**: assert `conv_start` for one cycle, clear the timeout tick counter, go to WAIT_CONV.
- **WAIT_CONV**:
  - On `conv_done`: latch `temp_latched`, clear `sensor_fault`, go to TRIG.
  - On timeout (tick counter reaches CONV_TIMEOUT): set `sensor_fault`, load `duty_next`=0, go to WAIT_WRAP.
  - If `conv_done` and timeout occur in the same cycle, `conv_done` wins.
- **TRIG**: hold `pid_trig`=1 for TRIG_LEN cycles, then go to SETTLE.
- **SETTLE**: `pid_trig`=0 for SETTLE_LEN cycles, then go to CAPTURE.
- **CAPTURE**: `duty_next` = clamp(`high_len`, 0, 1000), with a signed compare, truncated to 11 bits. Go to WAIT_WRAP.

Duty update and outputs:
- `duty` loads from `duty_next` only on `wrap`, so duty never changes mid-period.
- `heater_pwm` = `heater_open` && !`sensor_fault` && (`per_cnt` < `duty`). Registered.
- `fan_drv` = `fan_open` || `sensor_fault`. Registered.

Boundary conditions:
- `conv_done` outside WAIT_CONV is ignored.
- A `wrap` seen in any state other than WAIT_WRAP sets `overrun`. That period's sample is skipped and the FSM finishes its current sequence.
- `overrun` clears only on `rst` or when `enable` falls.
- `enable` low, in any state: next cycle the FSM goes to WAIT_WRAP. All counters are held at 0, and `duty`, `duty_next`, `pid_trig`, `conv_start`, `heater_pwm` and `fan_drv` are 0. `sensor_fault` and `temp_latched` are held.

## Timing
- **Reset values**: all outputs 0, FSM in WAIT_WRAP, all counters 0.
- **Enable rising** at cycle N: `conv_start` at N+1 and `per_cnt` counting from 0.
- **`conv_done` at cycle C**:
  - `pid_trig` high on cycles C+1..C+TRIG_LEN.
  - `high_len` sampled at cycle C+TRIG_LEN+SETTLE_LEN+1.
  - The new `duty` is applied at the next `wrap`.
- **Sample-to-output latency**: between one and two PWM periods.
- **`heater_pwm` edges**: rise on the `per_cnt`=0 tick and fall on the `per_cnt`=`duty` tick, each one clk cycle after the tick.
- `duty`=0 gives constant low; `duty`=1000 gives constant high.

## Structure
- Shared package `tc_pkg` holds:
  - `PWM_PERIOD`=1000
  - `DUTY_W`=11
  - `TEMP_W`=12
  - the FSM state enum `sched_state_t`
  - `clamp_duty()`
- One natural sub-module, `pwm_timebase`, containing `div_cnt`, `per_cnt`, `tick` and `wrap`, with a synchronous clear tied to `enable`.

## Test plan
Use TICK_DIV=2.
1. **Basic sequence.** `rst` then `enable`=1; `conv_done` 100 cycles after `conv_start` with `ds_data`=0x190; `high_len`=300. Required: `temp_latched`=0x190; `pid_trig` high for 4 cycles; `duty`=300 after the next `wrap`; `heater_pwm` high for 600 clk per 2000-clk period.
2. **Clamping.** `high_len`=-50 gives `duty`=0 and `heater_pwm` constantly 0. `high_len`=1500 gives `duty`=1000 and `heater_pwm` constantly 1 with `heater_open`=1.
3. **Timeout.** No `conv_done`. Required: `sensor_fault`=1 at tick 900 after `conv_start`; `heater_pwm`=0; `fan_drv`=1. A later valid `conv_done` clears `sensor_fault`.
4. **Simultaneous.** `conv_done` in the exact cycle the timeout expires: `sensor_fault` stays 0 and `pid_trig` is issued.
5. **Enable mid-sequence.** Drop `enable` during TRIG: `pid_trig` is 0 next cycle, `duty`=0, `heater_pwm`=0. Re-enable: `conv_start` pulses one cycle after the rising edge.
6. **Async reset.** Assert `rst` mid-period with `duty`=500: all outputs are 0 immediately, without waiting for a `clk` edge.
